mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported word memory between the CPU (port 0) and an I/O processor / DMA requester (port 1).
- Sits between both requesters and the memory: 17-bit word address, 32-bit data, 4 byte write enables, combinational read, write on rising clock.
- Sequences one access per grant using a req/ack handshake.
- Provides round-robin fairness, plus a CPU lock for atomic read-modify-write sequences.

---
 rtl/mem_arbiter_if.sv | 75 +++++++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if.sv
//
// Interfaces used by mem_arbiter.
//
// mem_arbiter_req_if : both requester ports.
//   port 0 (CPU) : req0, addr0, wren0, wdata0, lock0 -> ack0, rdata0
//   port 1 (I/O) : req1, addr1, wren1, wdata1        -> ack1, rdata1
//   modport master : the requesters (drive req/addr/wren/wdata/lock)
//   modport slave  : the arbiter    (drives ack/rdata)
//
// mem_arbiter_mem_if : the single-ported word memory.
//   address, write_en, data_out driven by the arbiter; data_in is the
//   memory's combinational read data.
//   modport master : the arbiter
//   modport slave  : the memory
// ---------------------------------------------------------------------------

interface mem_arbiter_req_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // CPU port
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [BE_W-1:0]   wren0;
  logic [DATA_W-1:0] wdata0;
  logic              lock0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  // I/O requester port
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [BE_W-1:0]   wren1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, addr0, wren0, wdata0, lock0,
    output req1, addr1, wren1, wdata1,
    input  ack0, rdata0, ack1, rdata1
  );

  modport slave (
    input  req0, addr0, wren0, wdata0, lock0,
    input  req1, addr1, wren1, wdata1,
    output ack0, rdata0, ack1, rdata1
  );
endinterface

interface mem_arbiter_mem_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   write_en;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;

  modport master (
    output address, write_en, data_out,
    input  data_in
  );

  modport slave (
    input  address, write_en, data_out,
    output data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter.sv
//
// Shares one single-ported word memory between the CPU (port 0) and an I/O
// processor / DMA requester (port 1). Each grant performs exactly one memory
// access (one ACCESS cycle) and answers with a one-cycle ack pulse plus the
// registered read data.
//
// Arbitration: round-robin on ties, port 0 wins the first tie after reset.
// A requester's req is ignored during the cycle its ack is high, so a held
// req cannot be granted twice. The CPU can hold the memory across several
// accesses with lock0 for atomic read-modify-write sequences.
//
// Ports:
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-low
//   req_if  : requester ports (slave modport of mem_arbiter_req_if)
//   mem_if  : memory port (master modport of mem_arbiter_mem_if)
//   busy    : high while an access is in progress (ACCESS state)
// ---------------------------------------------------------------------------

module mem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  mem_arbiter_req_if.slave    req_if,
  mem_arbiter_mem_if.master   mem_if,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t state;
  logic   winner;      // port owning the current ACCESS cycle
  logic   last_grant;  // port granted most recently (tie breaker)
  logic   locked;      // CPU holds the memory; port 1 is masked

  // -------------------------------------------------------------------------
  // Arbitration (evaluated in IDLE only)
  // -------------------------------------------------------------------------
  logic eff0;
  logic eff1;
  logic grant_valid;
  logic grant_port;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    eff0        = 1'b0;
    eff1        = 1'b0;
    grant_valid = 1'b0;
    grant_port  = 1'b0;

    // A port whose ack is high this cycle is still holding req from the
    // access just completed; that req must not start a second access.
    eff0 = req_if.req0 & ~req_if.ack0;
    eff1 = req_if.req1 & ~req_if.ack1 & ~locked;

    grant_valid = eff0 | eff1;
    if (eff0 && eff1) begin
      grant_port = ~last_grant;
    end else begin
      grant_port = eff1;
    end
  end

  // -------------------------------------------------------------------------
  // Memory side: combinational from state and the latched winner. The
  // requester holds addr/wren/wdata stable until its ack, so the live values
  // are sampled directly. Outside ACCESS everything is driven to zero, which
  // also means an asynchronous reset kills a pending write immediately.
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_wren;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    sel_addr  = '0;
    sel_wren  = '0;
    sel_wdata = '0;
    if (state == S_ACCESS) begin
      if (winner) begin
        sel_addr  = req_if.addr1;
        sel_wren  = req_if.wren1;
        sel_wdata = req_if.wdata1;
      end else begin
        sel_addr  = req_if.addr0;
        sel_wren  = req_if.wren0;
        sel_wdata = req_if.wdata0;
      end
    end
  end

  assign mem_if.address  = sel_addr;
  assign mem_if.write_en = sel_wren;
  assign mem_if.data_out = sel_wdata;
  assign busy            = (state == S_ACCESS);

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      winner     <= 1'b0;
      last_grant <= 1'b1;  // port 0 wins the first tie
      locked     <= 1'b0;
      req_if.ack0   <= 1'b0;
      req_if.ack1   <= 1'b0;
      // NOTE: the read-data registers are reset too; they are visible outputs
      // and must read as zero before the first access.
      req_if.rdata0 <= '0;
      req_if.rdata1 <= '0;
    end else begin
      // acks are single-cycle pulses
      req_if.ack0 <= 1'b0;
      req_if.ack1 <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            winner     <= grant_port;
            last_grant <= grant_port;
            state      <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          // The memory writes on this same edge; data_in still shows the
          // pre-write word, which is returned for writes as well as reads.
          if (winner) begin
            req_if.rdata1 <= mem_if.data_in;
            req_if.ack1   <= 1'b1;
          end else begin
            req_if.rdata0 <= mem_if.data_in;
            req_if.ack0   <= 1'b1;
            // Lock follows the CPU's lock0 of each access: set by a locked
            // access, released by the first unlocked one.
            locked        <= req_if.lock0;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter.sv
//
// Self-checking bench for mem_arbiter. A word-memory model hangs off the
// memory interface. Each issued access pushes its expected read data (the
// word before the access, taken from a reference memory) into a per-port
// queue; a monitor pops and compares on every ack. Directed sequences check
// latency, grant order and lock behaviour; a random phase runs both ports
// concurrently in disjoint address windows.
// ---------------------------------------------------------------------------

module tb_mem_arbiter;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 32;
  localparam int MEM_SZ  = 1 << ADDR_W;
  localparam int BUDGET  = 300;

  logic clock;
  logic reset;
  logic busy;

  mem_arbiter_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rq ();
  mem_arbiter_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mi ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .req_if (rq.slave),
    .mem_if (mi.master),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // -------------------------------------------------------------------------
  // Memory model (combinational read, byte-enabled write on rising edge)
  // -------------------------------------------------------------------------
  bit [31:0] mem     [0:MEM_SZ-1];
  bit [31:0] ref_mem [0:MEM_SZ-1];

  assign mi.data_in = mem[mi.address];

  always @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (mi.write_en[b]) mem[mi.address][8*b +: 8] <= mi.data_out[8*b +: 8];
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  typedef struct {
    logic [31:0] rdata;
    logic        lock;
  } exp_t;

  typedef struct {
    int port;
    int cyc;
  } ack_ev_t;

  exp_t    q0[$];
  exp_t    q1[$];
  ack_ev_t ack_log[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Monitor: pops expected data on every ack; tracks the lock at the
  // requirement level (lock state = lock0 of the most recent CPU access).
  // -------------------------------------------------------------------------
  logic tb_locked;
  logic prev_ack0;
  logic prev_ack1;
  exp_t e0;
  exp_t e1;

  always @(negedge clock) begin
    if (!reset) begin
      tb_locked = 1'b0;
      prev_ack0 = 1'b0;
      prev_ack1 = 1'b0;
    end else begin
      if (rq.ack0 && rq.ack1) check("double_ack", 1, 0);
      if (rq.ack0 && prev_ack0) check("ack0_width", 1, 0);
      if (rq.ack1 && prev_ack1) check("ack1_width", 1, 0);
      if (rq.ack0) begin
        check("ack0_expected", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          check("rdata0", rq.rdata0, e0.rdata);
          tb_locked = e0.lock;
        end
        ack_log.push_back('{port: 0, cyc: cyc});
      end
      if (rq.ack1) begin
        check("ack1_expected", q1.size() != 0, 1);
        check("ack1_while_locked", tb_locked, 0);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          check("rdata1", rq.rdata1, e1.rdata);
        end
        ack_log.push_back('{port: 1, cyc: cyc});
      end
      prev_ack0 = rq.ack0;
      prev_ack1 = rq.ack1;
    end
  end

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  task automatic set_port(input int p, input logic r, input logic [16:0] a,
                          input logic [3:0] we, input logic [31:0] wd, input logic lk);
    if (p == 0) begin
      rq.req0 = r; rq.addr0 = a; rq.wren0 = we; rq.wdata0 = wd; rq.lock0 = lk;
    end else begin
      rq.req1 = r; rq.addr1 = a; rq.wren1 = we; rq.wdata1 = wd;
    end
  endtask

  task automatic preload(input logic [16:0] a, input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // Called at posedge+1. Issues one access, waits for its ack, returns at the
  // posedge+1 after the ack cycle with req still high (caller drops it or
  // issues the next access). exp_lat=2 also checks uncontended latency/busy.
  task automatic port_access(input int p, input logic [16:0] a, input logic [3:0] we,
                             input logic [31:0] wd, input logic lk, input int exp_lat);
    int   start;
    int   n;
    logic got;
    exp_t e;
    start = cyc;
    e.rdata = ref_mem[a];
    e.lock  = lk;
    ref_mem[a] = merge(ref_mem[a], wd, we);
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    set_port(p, 1'b1, a, we, wd, lk);
    n   = 0;
    got = 1'b0;
    while (!got && n < BUDGET) begin
      @(negedge clock);
      n++;
      if (exp_lat == 2 && n == 2) check("busy_in_access", busy, 1);
      got = (p == 0) ? rq.ack0 : rq.ack1;
    end
    if (!got) check(p == 0 ? "ack0_timeout" : "ack1_timeout", 0, 1);
    else if (exp_lat > 0) check("latency", cyc - start, exp_lat);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_ports();
    set_port(0, 1'b0, '0, '0, '0, 1'b0);
    set_port(1, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Called at posedge+1; asserts reset mid-cycle (with inputs still held),
  // checks the reset state before any clock edge, then releases.
  task automatic apply_reset();
    #1 reset = 1'b0;
    #1;
    check("rst_ack0",     rq.ack0, 0);
    check("rst_ack1",     rq.ack1, 0);
    check("rst_rdata0",   rq.rdata0, 0);
    check("rst_rdata1",   rq.rdata1, 0);
    check("rst_busy",     busy, 0);
    check("rst_mem_addr", mi.address, 0);
    check("rst_mem_we",   mi.write_en, 0);
    check("rst_mem_wd",   mi.data_out, 0);
    idle_ports();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic rand_port(input int p, input int n_ops);
    int          gap;
    logic [16:0] a;
    logic [3:0]  we;
    logic        lk;
    for (int i = 0; i < n_ops; i++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        set_port(p, 1'b0, '0, '0, '0, 1'b0);
        repeat (gap) begin
          @(posedge clock);
          #1;
        end
      end
      a  = 17'((p == 0 ? 32'h100 : 32'h200) + $urandom_range(0, 63));
      we = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      lk = (p == 0) && (i != n_ops - 1) && ($urandom_range(0, 3) == 0);
      port_access(p, a, we, $urandom, lk, 0);
    end
    set_port(p, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  int k;

  initial begin
    reset = 1'b0;
    idle_ports();
    repeat (3) @(posedge clock);
    #1;
    check("init_busy", busy, 0);
    check("init_ack", {rq.ack0, rq.ack1}, 0);
    check("init_mem_we", mi.write_en, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Read, port 0 only
    preload(17'h010, 32'h12345678);
    port_access(0, 17'h010, 4'b0000, 32'h0, 1'b0, 2);
    set_port(0, 1'b0, '0, '0, '0, 1'b0);
    check("read_rdata0", rq.rdata0, 32'h12345678);

    // Byte write then read, port 1
    preload(17'h020, 32'h11223344);
    port_access(1, 17'h020, 4'b0110, 32'hAABBCCDD, 1'b0, 2);
    check("bytewrite_mem", mem[17'h020], 32'h11BBCC44);
    port_access(1, 17'h020, 4'b0000, 32'h0, 1'b0, 2);
    set_port(1, 1'b0, '0, '0, '0, 1'b0);
    check("bytewrite_readback", rq.rdata1, 32'h11BBCC44);

    // Tie after reset: grant order 0,1,0,1 every two cycles
    apply_reset();
    ack_log.delete();
    k = cyc;
    fork
      begin
        port_access(0, 17'h050, 4'b0000, 32'h0, 1'b0, 0);
        port_access(0, 17'h051, 4'b0000, 32'h0, 1'b0, 0);
        set_port(0, 1'b0, '0, '0, '0, 1'b0);
      end
      begin
        port_access(1, 17'h060, 4'b0000, 32'h0, 1'b0, 0);
        port_access(1, 17'h061, 4'b0000, 32'h0, 1'b0, 0);
        set_port(1, 1'b0, '0, '0, '0, 1'b0);
      end
    join
    check("tie_ack_count", ack_log.size(), 4);
    for (int i = 0; i < ack_log.size() && i < 4; i++) begin
      check("tie_port", ack_log[i].port, i % 2);
      check("tie_cycle", ack_log[i].cyc - k, 2 * (i + 1));
    end

    // Lock: locked read + unlocked write on port 0, port 1 pending throughout
    apply_reset();
    preload(17'h030, 32'hCAFE0030);
    preload(17'h031, 32'h0BADF00D);
    ack_log.delete();
    k = cyc;
    fork
      begin
        port_access(0, 17'h030, 4'b0000, 32'h0, 1'b1, 0);
        port_access(0, 17'h030, 4'b1111, 32'hDEADBEEF, 1'b0, 0);
        set_port(0, 1'b0, '0, '0, '0, 1'b0);
      end
      begin
        port_access(1, 17'h031, 4'b0000, 32'h0, 1'b0, 0);
        set_port(1, 1'b0, '0, '0, '0, 1'b0);
      end
    join
    check("lock_ack_count", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      check("lock_order0", ack_log[0].port, 0);
      check("lock_cyc0",   ack_log[0].cyc - k, 2);
      check("lock_order1", ack_log[1].port, 0);
      check("lock_cyc1",   ack_log[1].cyc - k, 5);
      check("lock_order2", ack_log[2].port, 1);
      check("lock_cyc2",   ack_log[2].cyc - k, 7);
    end
    check("lock_mem", mem[17'h030], 32'hDEADBEEF);

    // Reset in the middle of a port-0 write's ACCESS cycle
    preload(17'h040, 32'h55AA55AA);
    set_port(0, 1'b1, 17'h040, 4'b1111, 32'h01020304, 1'b0);
    @(posedge clock);
    #1;
    check("midrst_busy_before", busy, 1);
    check("midrst_we_before", mi.write_en, 4'b1111);
    apply_reset();
    check("midrst_mem", mem[17'h040], 32'h55AA55AA);
    repeat (3) begin
      @(negedge clock);
      check("midrst_no_ack0", rq.ack0, 0);
    end
    @(posedge clock);
    #1;

    // Idle: nothing happens on the memory for 10 cycles
    repeat (10) begin
      @(negedge clock);
      check("idle_outputs", {mi.write_en, mi.address, busy, rq.ack0, rq.ack1}, 0);
    end
    @(posedge clock);
    #1;

    // Random concurrent traffic in disjoint windows
    for (int a = 0; a < 64; a++) begin
      preload(17'(32'h100 + a), $urandom);
      preload(17'(32'h200 + a), $urandom);
    end
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (4) @(posedge clock);
    #1;
    for (int a = 0; a < 64; a++) begin
      check("final_mem_p0", mem[17'(32'h100 + a)], ref_mem[17'(32'h100 + a)]);
      check("final_mem_p1", mem[17'(32'h200 + a)], ref_mem[17'(32'h200 + a)]);
    end
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
